// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a five-stage MIPS pipeline.
// Holds the PC, drives the asynchronous instruction ROM address, and latches the
// fetched word into ID. It also applies ID-stage redirects, honours hazard stalls,
// and keeps sticky misalignment and performance counters for debug.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ID_jumpTaken,
  input  logic [31:0] ID_jumpTarget,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_pc4,
  output logic        ID_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  // The per-cycle decision, in priority order: a stall beats a redirect, and a
  // redirect beats a normal fetch.
  typedef enum logic [1:0] {
    ACT_FETCH    = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIRECT = 2'd2
  } action_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  action_e     action;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        target_misaligned;

  // All PC adds wrap modulo 2^32 by construction of the 32-bit sum.
  assign pc_plus4          = pc + 32'd4;
  assign target_aligned    = {ID_jumpTarget[31:2], 2'b00};
  assign target_misaligned = |ID_jumpTarget[1:0];

  // The ROM is read asynchronously at the current PC, so the address holds during a stall.
  assign imem_addr = pc;

  // Choose this cycle's action. While stalled, the branch operands are not valid yet,
  // so a simultaneous jump is ignored. ID presents it again once the stall clears.
  always_comb begin
    // NOTE: default first so every path assigns action and no latch is inferred.
    action = ACT_FETCH;
    if (stall) begin
      action = ACT_HOLD;
    end else if (ID_jumpTaken) begin
      action = ACT_REDIRECT;
    end
  end

  // Program counter: reset vector, hold, redirect target (low bits dropped), or sequential.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      unique case (action)
        ACT_HOLD:     pc <= pc;
        ACT_REDIRECT: pc <= target_aligned;
        default:      pc <= pc_plus4;
      endcase
    end
  end

  // IF/ID register. A redirect squashes the wrong-path word with a NOP bubble. The
  // bubble still records the squashed PC so that ID_pc/ID_pc4 stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_instr <= NOP_INSTR;
      ID_pc    <= 32'd0;
      ID_pc4   <= 32'd0;
      ID_valid <= 1'b0;
    end else begin
      unique case (action)
        ACT_HOLD: begin
          ID_instr <= ID_instr;
          ID_pc    <= ID_pc;
          ID_pc4   <= ID_pc4;
          ID_valid <= ID_valid;
        end
        ACT_REDIRECT: begin
          ID_instr <= NOP_INSTR;
          ID_pc    <= pc;
          ID_pc4   <= pc_plus4;
          ID_valid <= 1'b0;
        end
        default: begin
          ID_instr <= imem_rdata;
          ID_pc    <= pc;
          ID_pc4   <= pc_plus4;
          ID_valid <= 1'b1;
        end
      endcase
    end
  end

  // Sticky misalignment flag. Only a redirect that is actually taken can set it,
  // and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (action == ACT_REDIRECT && target_misaligned) begin
      misalign_err <= 1'b1;
    end
  end

  // Debug counters. Both wrap silently at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (action == ACT_FETCH) fetch_count <= fetch_count + 32'd1;
      if (action == ACT_HOLD)  stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A table of directed vectors is applied one
// clock edge at a time, followed by a hand-written long-stall sequence.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ID_jumpTaken;
  logic [31:0] ID_jumpTarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ID_instr;
  logic [31:0] ID_pc;
  logic [31:0] ID_pc4;
  logic        ID_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .ID_jumpTaken  (ID_jumpTaken),
    .ID_jumpTarget (ID_jumpTarget),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ID_instr      (ID_instr),
    .ID_pc         (ID_pc),
    .ID_pc4        (ID_pc4),
    .ID_valid      (ID_valid),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
  );

  // Asynchronous-read ROM: three fixed words, and every other address returns addr ^ C0DE0000.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h1111_1111;
      32'h0000_3004: return 32'h2222_2222;
      32'h0000_3008: return 32'h3333_3333;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        jmp;
    logic [31:0] target;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_addr;
    logic        e_mis;
    logic [31:0] e_fc;
    logic [31:0] e_sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic j,
                              input logic [31:0] t, input logic v,
                              input logic [31:0] ins, input logic [31:0] p,
                              input logic [31:0] p4, input logic [31:0] ad,
                              input logic m, input logic [31:0] fc,
                              input logic [31:0] sc);
    vec_t x;
    x.rst = r; x.stall = s; x.jmp = j; x.target = t;
    x.e_valid = v; x.e_instr = ins; x.e_pc = p; x.e_pc4 = p4;
    x.e_addr = ad; x.e_mis = m; x.e_fc = fc; x.e_sc = sc;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; ID_jumpTaken = j; ID_jumpTarget = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ID_jumpTaken = 1'b0; ID_jumpTarget = 32'd0;

    //                  rst stall jmp target        valid instr          ID_pc          ID_pc4         imem_addr      mis fc  sc
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h0,          32'h0,          32'h0000_3000, 0, 0, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h1111_1111,  32'h3000,       32'h3004,       32'h0000_3004, 0, 1, 0)); // 1 first fetch
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h2222_2222,  32'h3004,       32'h3008,       32'h0000_3008, 0, 2, 0)); // 2
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h2222_2222,  32'h3004,       32'h3008,       32'h0000_3008, 0, 2, 1)); // 3 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h2222_2222,  32'h3004,       32'h3008,       32'h0000_3008, 0, 2, 2)); // 4 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h2222_2222,  32'h3004,       32'h3008,       32'h0000_3008, 0, 2, 3)); // 5 stall
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3333_3333,  32'h3008,       32'h300C,       32'h0000_300C, 0, 3, 3)); // 6 no gap
    vecs.push_back(mk(0, 0, 1, 32'h3100,       0, 32'h0,          32'h300C,       32'h3010,       32'h0000_3100, 0, 3, 3)); // 7 jump -> bubble
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hC0DE_3100,  32'h3100,       32'h3104,       32'h0000_3104, 0, 4, 3)); // 8 target
    vecs.push_back(mk(0, 1, 1, 32'h3200,       1, 32'hC0DE_3100,  32'h3100,       32'h3104,       32'h0000_3104, 0, 4, 4)); // 9 stall wins
    vecs.push_back(mk(0, 1, 1, 32'h3200,       1, 32'hC0DE_3100,  32'h3100,       32'h3104,       32'h0000_3104, 0, 4, 5)); // 10 stall wins
    vecs.push_back(mk(0, 0, 1, 32'h3200,       0, 32'h0,          32'h3104,       32'h3108,       32'h0000_3200, 0, 4, 5)); // 11 jump taken
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hC0DE_3200,  32'h3200,       32'h3204,       32'h0000_3204, 0, 5, 5)); // 12 target in ID
    vecs.push_back(mk(0, 0, 1, 32'h3203,       0, 32'h0,          32'h3204,       32'h3208,       32'h0000_3200, 1, 5, 5)); // 13 misaligned
    vecs.push_back(mk(0, 0, 1, 32'h3300,       0, 32'h0,          32'h3200,       32'h3204,       32'h0000_3300, 1, 5, 5)); // 14 jump on bubble
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hC0DE_3300,  32'h3300,       32'h3304,       32'h0000_3304, 1, 6, 5)); // 15 sticky
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,          32'h3304,       32'h3308,       32'hFFFF_FFFC, 1, 6, 5)); // 16 preset top
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3F21_FFFC,  32'hFFFF_FFFC,  32'h0,          32'h0000_0000, 1, 7, 5)); // 17 wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hC0DE_0000,  32'h0,          32'h4,          32'h0000_0004, 1, 8, 5)); // 18
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'hC0DE_0000,  32'h0,          32'h4,          32'h0000_0004, 1, 8, 6)); // 19 stall
    vecs.push_back(mk(1, 1, 1, 32'h5000,       0, 32'h0,          32'h0,          32'h0,          32'h0000_3000, 0, 0, 0)); // 20 rst mid-stall
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h1111_1111,  32'h3000,       32'h3004,       32'h0000_3004, 0, 1, 0)); // 21 restart

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].jmp, vecs[i].target);
      check($sformatf("v%0d_valid", i), {31'd0, ID_valid},     {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_instr", i), ID_instr,              vecs[i].e_instr);
      check($sformatf("v%0d_pc", i),    ID_pc,                 vecs[i].e_pc);
      check($sformatf("v%0d_pc4", i),   ID_pc4,                vecs[i].e_pc4);
      check($sformatf("v%0d_addr", i),  imem_addr,             vecs[i].e_addr);
      check($sformatf("v%0d_mis", i),   {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
      check($sformatf("v%0d_fcnt", i),  fetch_count,           vecs[i].e_fc);
      check($sformatf("v%0d_scnt", i),  stall_count,           vecs[i].e_sc);
    end

    // Long stall: the ID-stage word (0x3000) stays resident and the ROM address stays put.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check($sformatf("ls%0d_pc", k),   ID_pc,       32'h0000_3000);
      check($sformatf("ls%0d_instr", k), ID_instr,   32'h1111_1111);
      check($sformatf("ls%0d_addr", k), imem_addr,   32'h0000_3004);
      check($sformatf("ls%0d_scnt", k), stall_count, 32'(k + 1));
    end
    // Release: the next word follows without a gap or a duplicate.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("rel_instr", ID_instr,    32'h2222_2222);
    check("rel_pc",    ID_pc,       32'h0000_3004);
    check("rel_fcnt",  fetch_count, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("rel2_instr", ID_instr,  32'h3333_3333);
    check("rel2_addr",  imem_addr, 32'h0000_300C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, latches the fetched instruction into the ID stage, and obeys the `stall` produced by the ID-stage hazard detector. It also applies redirects for jumps and branches resolved in ID, and keeps sticky error and performance counters for debug.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `stall`  in  1  from hazard detector; freezes PC and IF/ID register.
- `ID_jumpTaken`  in  1  ID-stage jump/branch resolved taken this cycle.
- `ID_jumpTarget`  in  32  redirect target, valid when `ID_jumpTaken`.
- `imem_addr`  out  32  instruction memory byte address, equals current PC (combinational).
- `imem_rdata`  in  32  instruction word at `imem_addr`; asynchronous-read ROM, same cycle.
- `ID_instr`  out  32  instruction in ID; 32'h0000_0000 (sll $0,$0,0 NOP) when bubble.
- `ID_pc`  out  32  address of `ID_instr`.
- `ID_pc4`  out  32  `ID_pc` + 4, for link instructions.
- `ID_valid`  out  1  `ID_instr` is a real fetched instruction, not a bubble.
- `misalign_err`  out  1  sticky: a redirect target had nonzero bits [1:0].
- `fetch_count`  out  32  number of valid instructions delivered to ID.
- `stall_count`  out  32  number of cycles with `stall` high.

## Operation

- Reset values (`rst` high at edge): PC = `RESET_PC`; `ID_instr` = 0, `ID_pc` = 0, `ID_pc4` = 0, `ID_valid` = 0; `misalign_err` = 0; both counters = 0. `rst` overrides all other inputs.
- Per-cycle priority, evaluated at each rising edge when `rst` is low:
  - `stall` high: PC, `ID_instr`, `ID_pc`, `ID_pc4`, `ID_valid` all hold. `ID_jumpTaken` is ignored, because branch operands are not yet valid. `stall_count` += 1.
  - Else `ID_jumpTaken` high: PC <= {`ID_jumpTarget`[31:2], 2'b00}. IF/ID loads a bubble: `ID_instr` = 0, `ID_valid` = 0, `ID_pc` = PC, `ID_pc4` = PC + 4. The wrong-path instruction is squashed; there are no delay slots. If `ID_jumpTarget`[1:0] != 0, set `misalign_err`, which stays set until reset.
  - Else (normal fetch): PC <= PC + 4. `ID_instr` <= `imem_rdata`, `ID_pc` <= PC, `ID_pc4` <= PC + 4, `ID_valid` <= 1. `fetch_count` += 1.
- Arithmetic: all PC adds are modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0 with no flag. Counters wrap from 32'hFFFF_FFFF to 0.
- `imem_addr` = PC at all times, including during stall, so the ROM output is stable.

## Timing

- Fetch latency is 1 cycle: the word at PC is visible on `ID_instr` after the next rising edge.
- First fetch: in the first cycle after `rst` falls, `imem_addr` = `RESET_PC`. After that edge, `ID_instr` = mem[`RESET_PC`] and `imem_addr` = `RESET_PC` + 4.
- Taken redirect costs exactly 1 bubble cycle. The target instruction reaches ID two edges after `ID_jumpTaken` is sampled.
- Stall of N cycles extends the ID-stage instruction's residence by N cycles. No instruction is lost or duplicated.
- If `stall` and `ID_jumpTaken` are both high, the stall wins. The jump is re-presented by ID in the first cycle `stall` falls and is taken then.
- A redirect while `ID_valid` = 0 is still honoured; the bubble flag does not gate `ID_jumpTaken`.
- `rst` asserted mid-stall or mid-redirect: the next edge yields pure reset state, and the pending jump is dropped.

## Test plan

- Reset, then free-run with ROM[0x3000..] = 0x11111111, 0x22222222, 0x33333333 -> `ID_instr` sequence 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; `ID_pc` = 0x3000, 0x3004, 0x3008; `fetch_count` = 3.
- Hold `stall` high 3 cycles while `ID_pc` = 0x3004 -> `ID_pc`, `ID_instr` and `imem_addr` (0x3008) unchanged for 3 cycles; `stall_count` = 3; next instruction 0x3008 follows with no gap.
- `ID_jumpTaken` = 1 with target 0x3100 at `ID_pc` = 0x3004 -> next cycle `ID_valid` = 0, `ID_instr` = 0; following cycle `ID_pc` = 0x3100, `ID_valid` = 1.
- `stall` and `ID_jumpTaken` both high for 2 cycles, then `stall` low with jump still high (target 0x3200) -> PC frozen for 2 cycles, then redirect; `ID_pc` = 0x3200 two edges after `stall` falls.
- Jump to 0x3203 -> PC = 0x3200 and `misalign_err` = 1; stays 1 through later fetches and clears only on `rst`.
- PC preset via jump to 0xFFFFFFFC -> next `imem_addr` = 0x00000000. Then assert `rst` mid-stall -> all outputs return to reset values and `imem_addr` = 0x3000.
